// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - ID/EX operand stage: EX/MEM/WB forwarding, load-use stall, write-back port
module operand_fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [3:0]  rs_a,
  input  logic [3:0]  rs_b,
  input  logic [3:0]  rd,
  input  logic        rd_we,
  input  logic        is_load,
  input  logic        flush,
  input  logic [15:0] rf_data_a,
  input  logic [15:0] rf_data_b,
  input  logic [15:0] ex_result,
  input  logic [15:0] mem_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [15:0] ex_op_a,
  output logic [15:0] ex_op_b,
  output logic        rf_write,
  output logic [3:0]  rf_addr,
  output logic [15:0] rf_data
);

  logic        ex_v_q, ex_we_q, ex_ld_q;
  logic [3:0]  ex_rd_q;
  logic        mem_v_q, mem_we_q, mem_ld_q;
  logic [3:0]  mem_rd_q;
  logic [15:0] mem_data_q;
  logic        wb_v_q, wb_we_q;
  logic [3:0]  wb_rd_q;
  logic [15:0] wb_data_q;
  logic [15:0] op_a_q, op_b_q;

  logic        ex_v_d, ex_we_d, ex_ld_d;
  logic [3:0]  ex_rd_d;
  logic [15:0] op_a_d, op_b_d;
  logic [15:0] mem_fwd;
  logic        ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic        accept;

  assign mem_fwd = mem_ld_q ? mem_result : mem_data_q;

  assign ex_hit_a  = ex_v_q  & ex_we_q  & (ex_rd_q  == rs_a) & (rs_a != 4'd0);
  assign ex_hit_b  = ex_v_q  & ex_we_q  & (ex_rd_q  == rs_b) & (rs_b != 4'd0);
  assign mem_hit_a = mem_v_q & mem_we_q & (mem_rd_q == rs_a) & (rs_a != 4'd0);
  assign mem_hit_b = mem_v_q & mem_we_q & (mem_rd_q == rs_b) & (rs_b != 4'd0);
  assign wb_hit_a  = wb_v_q  & wb_we_q  & (wb_rd_q  == rs_a) & (rs_a != 4'd0);
  assign wb_hit_b  = wb_v_q  & wb_we_q  & (wb_rd_q  == rs_b) & (rs_b != 4'd0);

  // A load in EX has no data yet; one cycle later it is forwarded from mem_result.
  assign stall  = issue_valid & ~flush & ex_ld_q & (ex_hit_a | ex_hit_b);
  assign accept = issue_valid & ~flush & ~stall;

  // Youngest producer wins; R0 reads as zero.
  always_comb begin
    op_a_d = rf_data_a;
    if (rs_a == 4'd0)              op_a_d = 16'h0000;
    else if (ex_hit_a && !ex_ld_q) op_a_d = ex_result;
    else if (mem_hit_a)            op_a_d = mem_fwd;
    else if (wb_hit_a)             op_a_d = wb_data_q;
  end

  always_comb begin
    op_b_d = rf_data_b;
    if (rs_b == 4'd0)              op_b_d = 16'h0000;
    else if (ex_hit_b && !ex_ld_q) op_b_d = ex_result;
    else if (mem_hit_b)            op_b_d = mem_fwd;
    else if (wb_hit_b)             op_b_d = wb_data_q;
  end

  always_comb begin
    ex_v_d  = 1'b0;
    ex_we_d = 1'b0;
    ex_ld_d = 1'b0;
    ex_rd_d = 4'd0;
    if (accept) begin
      ex_v_d  = 1'b1;
      ex_we_d = rd_we;
      ex_ld_d = is_load;
      ex_rd_d = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q     <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
      ex_rd_q    <= 4'd0;
      mem_v_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_ld_q   <= 1'b0;
      mem_rd_q   <= 4'd0;
      mem_data_q <= 16'h0000;
      wb_v_q     <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 4'd0;
      wb_data_q  <= 16'h0000;
      op_a_q     <= 16'h0000;
      op_b_q     <= 16'h0000;
    end else begin
      wb_v_q     <= mem_v_q;
      wb_we_q    <= mem_we_q;
      wb_rd_q    <= mem_rd_q;
      wb_data_q  <= mem_fwd;
      mem_v_q    <= ex_v_q;
      mem_we_q   <= ex_we_q;
      mem_ld_q   <= ex_ld_q;
      mem_rd_q   <= ex_rd_q;
      mem_data_q <= ex_result;
      ex_v_q     <= ex_v_d;
      ex_we_q    <= ex_we_d;
      ex_ld_q    <= ex_ld_d;
      ex_rd_q    <= ex_rd_d;
      if (accept) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
      end
    end
  end

  assign ex_valid = ex_v_q;
  assign ex_op_a  = op_a_q;
  assign ex_op_b  = op_b_q;
  assign rf_write = wb_v_q & wb_we_q & (wb_rd_q != 4'd0);
  assign rf_addr  = wb_rd_q;
  assign rf_data  = wb_data_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, rd_we, is_load, flush;
  logic [3:0]  rs_a, rs_b, rd;
  logic [15:0] rf_data_a, rf_data_b, ex_result, mem_result;
  logic        stall, ex_valid, rf_write;
  logic [15:0] ex_op_a, ex_op_b, rf_data;
  logic [3:0]  rf_addr;

  int total = 0;
  int bad   = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .rd_we(rd_we), .is_load(is_load),
    .flush(flush), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_result(ex_result), .mem_result(mem_result),
    .stall(stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  // Model: history of accepted instructions indexed by issue cycle.
  // During cycle c, the instruction issued in c-1 is in EX, c-2 in MEM, c-3 in WB.
  logic        h_v  [512];
  logic        h_we [512];
  logic        h_ld [512];
  logic [3:0]  h_rd [512];
  logic [15:0] h_val[512];
  int          cyc;
  logic [15:0] exp_a, exp_b;

  task automatic model_clear();
    for (int i = 0; i < 512; i++) begin
      h_v[i] = 1'b0; h_we[i] = 1'b0; h_ld[i] = 1'b0; h_rd[i] = 4'd0; h_val[i] = 16'h0;
    end
    exp_a = 16'h0;
    exp_b = 16'h0;
  endtask

  function automatic logic [15:0] model_fwd(input logic [3:0] s, input logic [15:0] rfv);
    int k;
    if (s == 4'd0) return 16'h0000;
    for (int age = 1; age <= 3; age++) begin
      k = cyc - age;
      if (h_v[k] && h_we[k] && h_rd[k] == s) begin
        if (age == 1) begin
          if (!h_ld[k]) return ex_result;
        end else if (age == 2) begin
          return h_ld[k] ? mem_result : h_val[k];
        end else begin
          return h_val[k];
        end
      end
    end
    return rfv;
  endfunction

  function automatic logic model_stall();
    int k;
    k = cyc - 1;
    if (!issue_valid || flush) return 1'b0;
    if (!(h_v[k] && h_we[k] && h_ld[k] && h_rd[k] != 4'd0)) return 1'b0;
    return (h_rd[k] == rs_a) || (h_rd[k] == rs_b);
  endfunction

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      if (h_v[cyc-1] && !h_ld[cyc-1]) h_val[cyc-1] = ex_result;
      if (h_v[cyc-2] &&  h_ld[cyc-2]) h_val[cyc-2] = mem_result;
      if (issue_valid && !flush && !model_stall()) begin
        exp_a = model_fwd(rs_a, rf_data_a);
        exp_b = model_fwd(rs_b, rf_data_b);
        h_v[cyc] = 1'b1; h_we[cyc] = rd_we; h_ld[cyc] = is_load; h_rd[cyc] = rd;
      end else begin
        h_v[cyc] = 1'b0;
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic w;
    int   k;
    k = cyc - 3;
    w = rst_n && h_v[k] && h_we[k] && h_rd[k] != 4'd0;
    chk("m_stall", {31'd0, stall}, {31'd0, rst_n ? model_stall() : 1'b0});
    chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, rst_n && h_v[cyc-1]});
    chk("m_ex_op_a", {16'd0, ex_op_a}, {16'd0, exp_a});
    chk("m_ex_op_b", {16'd0, ex_op_b}, {16'd0, exp_b});
    chk("m_rf_write", {31'd0, rf_write}, {31'd0, w});
    if (w) begin
      chk("m_rf_addr", {28'd0, rf_addr}, {28'd0, h_rd[k]});
      chk("m_rf_data", {16'd0, rf_data}, {16'd0, h_val[k]});
    end else if (!rst_n) begin
      chk("m_rf_addr_rst", {28'd0, rf_addr}, 32'd0);
      chk("m_rf_data_rst", {16'd0, rf_data}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                     input logic we, input logic ld);
    issue_valid = 1'b1; rs_a = a; rs_b = b; rd = d; rd_we = we; is_load = ld;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0; rd_we = 1'b0; is_load = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_ex_op_a"}, {16'd0, ex_op_a}, 32'd0);
    chk({tag, "_ex_op_b"}, {16'd0, ex_op_b}, 32'd0);
    chk({tag, "_rf_write"}, {31'd0, rf_write}, 32'd0);
    chk({tag, "_rf_addr"}, {28'd0, rf_addr}, 32'd0);
    chk({tag, "_rf_data"}, {16'd0, rf_data}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    cyc = 8;
    model_clear();
    rst_n = 1'b0;
    issue_valid = 1'b0; rd_we = 1'b0; is_load = 1'b0; flush = 1'b0;
    rs_a = 4'd0; rs_b = 4'd0; rd = 4'd0;
    rf_data_a = 16'hA5A5; rf_data_b = 16'h5A5A;
    ex_result = 16'h0000; mem_result = 16'h0000;
    tick();
    tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // R1 <- R0 op R0
    iss(4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    rf_data_a = 16'hFFFF;
    tick();
    chk("t1_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("t1_ex_op_a", {16'd0, ex_op_a}, 32'h0000);
    ex_result = 16'h1234;
    issue_valid = 1'b0;
    tick();
    ex_result = 16'h0000;
    tick();
    chk("t1_rf_write", {31'd0, rf_write}, 32'd1);
    chk("t1_rf_addr", {28'd0, rf_addr}, 32'd1);
    chk("t1_rf_data", {16'd0, rf_data}, 32'h1234);
    idle(3);

    // Back-to-back ALU dependency
    iss(4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    tick();
    ex_result = 16'h00AA;
    iss(4'd2, 4'd0, 4'd5, 1'b1, 1'b0);
    #1;
    chk("t2_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t2_ex_op_a", {16'd0, ex_op_a}, 32'h00AA);
    ex_result = 16'h0777;
    idle(4);

    // Load-use
    iss(4'd0, 4'd0, 4'd3, 1'b1, 1'b1);
    tick();
    iss(4'd0, 4'd3, 4'd6, 1'b1, 1'b0);
    ex_result = 16'h7777;
    #1;
    chk("t3_stall_on", {31'd0, stall}, 32'd1);
    tick();
    mem_result = 16'hBEEF;
    #1;
    chk("t3_stall_off", {31'd0, stall}, 32'd0);
    chk("t3_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("t3_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("t3_ex_op_b", {16'd0, ex_op_b}, 32'hBEEF);
    mem_result = 16'h0000;
    idle(4);

    // Youngest wins
    iss(4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    tick();
    ex_result = 16'h0001;
    iss(4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    tick();
    ex_result = 16'h0002;
    iss(4'd4, 4'd4, 4'd0, 1'b0, 1'b0);
    tick();
    chk("t4_ex_op_a", {16'd0, ex_op_a}, 32'h0002);
    chk("t4_ex_op_b", {16'd0, ex_op_b}, 32'h0002);
    idle(4);

    // R0 protection
    iss(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    tick();
    ex_result = 16'h5555;
    rf_data_a = 16'hFFFF;
    iss(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("t5_ex_op_a", {16'd0, ex_op_a}, 32'h0000);
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_rf_write", {31'd0, rf_write}, 32'd0);
      tick();
    end
    idle(2);

    // Flush during load-use stall
    iss(4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
    tick();
    iss(4'd7, 4'd0, 4'd8, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("t6_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t6_ex_valid", {31'd0, ex_valid}, 32'd0);
    idle(4);

    // Reset with writes in flight
    iss(4'd0, 4'd0, 4'd8, 1'b1, 1'b0);
    ex_result = 16'h0808;
    tick();
    iss(4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    tick();
    iss(4'd0, 4'd0, 4'd10, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk_zero_outputs("t7");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_rf_write", {31'd0, rf_write}, 32'd0);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-to-execute operand stage of the 16-bit pipelined CPU, directly downstream of the 16 x 16 register file. It takes the two raw read ports of the register file and replaces stale values with in-flight results from EX, MEM and WB. It detects load-use hazards and stalls issue for one cycle. It holds the ID/EX pipeline register. It also drives the register-file write port from its own WB slot.

## Interface
Parameters:
- none (data width 16, register index 4 bits, fixed by the ISA)

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decoded instruction present in ID
- rs_a, rs_b  in  4 each  source register indices (also drive register-file read select {rs_a, rs_b})
- rd  in  4  destination register index
- rd_we  in  1  instruction writes rd
- is_load  in  1  instruction is a load; its result appears on mem_result in MEM
- flush  in  1  kill the instruction currently in ID
- rf_data_a, rf_data_b  in  16 each  combinational register-file read data for rs_a / rs_b
- ex_result  in  16  ALU result of the instruction in EX slot
- mem_result  in  16  load data of the instruction in MEM slot
- stall  out  1  combinational; ID must hold its instruction this cycle
- ex_valid  out  1  ID/EX register valid
- ex_op_a, ex_op_b  out  16 each  forwarded operands latched for EX
- rf_write  out  1  register-file write strobe, high for the whole WB cycle
- rf_addr  out  4  write index
- rf_data  out  16  write data

## Operation
- There are three internal slots: EX, MEM and WB. Each holds {valid, rd, we, load}. MEM and WB also hold a 16-bit data field.
- Every clock edge advances all slots (no downstream back-pressure):
  - WB <= MEM, with data = mem_result if MEM.load, else MEM.data.
  - MEM <= EX, with data = ex_result.
  - EX <= accepted issue, or a bubble.
- An issue is accepted when issue_valid & !stall & !flush. Otherwise EX loads a bubble (valid=0). Its ex_op_a/ex_op_b hold their previous values.
- A slot is a hit for source s when slot.valid & slot.we & slot.rd == s & s != 0.
- Operand selection per source uses the youngest hit first:
  - EX hit, not a load: ex_result.
  - MEM hit: mem_result if MEM.load, else MEM.data.
  - WB hit: WB.data.
  - No hit: rf_data_x.
  - Source 0 always yields 0, regardless of rf_data.
- stall = issue_valid & !flush & (EX hit on rs_a or rs_b with EX.load). The stall lasts exactly 1 cycle, because the load moves to MEM and is then forwarded from mem_result.
- Register-file write-back:
  - rf_write = WB.valid & WB.we & WB.rd != 0.
  - rf_addr = WB.rd and rf_data = WB.data, both registered, so they are stable for the full cycle.
  - Write-back to R0 is suppressed.
- flush has priority over stall. A flushed instruction never enters EX, and stall is 0 that cycle.

## Timing
- Reset (rst_n low, asynchronous): all slot valids = 0. ex_valid = 0, ex_op_a = ex_op_b = 0, rf_write = 0, rf_addr = 0, rf_data = 0. stall = 0.
- Deassertion takes effect at the next rising edge. Reset mid-pipeline discards all in-flight writes, and no rf_write is produced for them.
- The instruction issues in cycle n.
  - Cycle n+1: in EX (ex_valid = 1); ex_result is sampled for it.
  - Cycle n+2: in MEM; mem_result is sampled if it is a load.
  - Cycle n+3: rf_write = 1.
  - Write-back latency: issue to rf_write = 3 cycles.
- Back-to-back dependent ALU ops incur 0 stall cycles.
- A load followed by a dependent op incurs exactly 1 stall cycle.
- An instruction in WB that matches a source is forwarded in the same cycle. The register-file write and the read do not need to be ordered.
- Two slots may hit simultaneously with the same rd. The youngest value always wins.

## Test plan
- Reset, then issue R1 <- (R0, R0) with ex_result = 16'h1234 → ex_op_a = 0 next cycle; at cycle 3: rf_write = 1, rf_addr = 1, rf_data = 16'h1234.
- Back-to-back dependency, no stall:
  - Stimulus: R2 <- with ex_result = 16'h00AA, then issue rs_a = 2 next cycle.
  - Required: ex_op_a = 16'h00AA, stall never asserted.
- Load-use:
  - Stimulus: load R3, then a dependent op with rs_b = 3, and mem_result = 16'hBEEF in the MEM cycle.
  - Required: stall = 1 for exactly 1 cycle, one bubble (ex_valid = 0), then ex_op_b = 16'hBEEF.
- Youngest-wins:
  - Stimulus: R4 written with 16'h0001 then 16'h0002, then read R4 while both are in flight.
  - Required: ex_op_a = 16'h0002.
- R0 protection:
  - Stimulus: an instruction with rd = 0, rd_we = 1, then read R0 with rf_data_a = 16'hFFFF.
  - Required: ex_op_a = 0, and rf_write stays 0.
- flush and mid-operation reset:
  - flush during a load-use stall → stall = 0 and ex_valid = 0 next cycle.
  - Pulse rst_n low with 3 writes in flight → no rf_write afterward, and all outputs are 0 immediately.
